// File: rtl/mac_operand_sequencer_if.sv
// Host-facing streams of the MAC operand sequencer: operand-pair input and result output.
interface mac_operand_sequencer_if;
  localparam int unsigned DATA_W = 8;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_ovf;

  // Host side: offers operand pairs, consumes results.
  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data, res_ovf
  );

  // Sequencer side: accepts operand pairs, produces results.
  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Front-end controller for the 4x4 MAC: buffers {b,a} pairs, issues a programmed
// number of them after clearing the MAC, and returns the wrapped dot product.
module mac_operand_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  mac_operand_sequencer_if.slave bus,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  output logic [3:0]             mac_a,
  output logic [3:0]             mac_b,
  output logic                   mac_en,
  output logic                   mac_clr,
  input  logic [7:0]             acc_in,
  output logic                   busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_ptr_nxt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [LEN_W-1:0] remaining;
  logic [7:0]      prev_acc;
  logic            en_d;
  logic            push_c;
  logic            wrap_c;
  logic [7:0]      head_nxt_c;

  // FIFO bookkeeping for the coming edge; a pop happens exactly when mac_en is high.
  // When the FIFO drains to empty and a push lands in the same edge, the new head
  // is the incoming word, so it is bypassed rather than read from storage.
  always_comb begin
    push_c     = bus.in_valid && bus.in_ready;
    rd_ptr_nxt = rd_ptr + AW'(mac_en);
    count_nxt  = count + CW'(push_c) - CW'(mac_en);
    head_nxt_c = (push_c && (wr_ptr == rd_ptr_nxt)) ? bus.in_data : mem[rd_ptr_nxt];
    wrap_c     = en_d && (acc_in < prev_acc);
  end

  // Operand storage.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= bus.in_data;
  end

  // Sequencer FSM, FIFO pointers, overflow tracking and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      remaining     <= '0;
      prev_acc      <= '0;
      en_d          <= 1'b0;
      mac_a         <= '0;
      mac_b         <= '0;
      mac_en        <= 1'b0;
      mac_clr       <= 1'b0;
      busy          <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_ovf   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      bus.in_ready <= (count_nxt != CW'(DEPTH));

      // acc_in reflects the product issued one cycle earlier; a drop means a wrap.
      en_d <= mac_en;
      if (en_d) prev_acc <= acc_in;
      if (wrap_c) bus.res_ovf <= 1'b1;

      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      mac_a   <= '0;
      mac_b   <= '0;

      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              state       <= CLEAR;
              remaining   <= len;
              bus.res_ovf <= 1'b0;
              mac_clr     <= 1'b1;
            end else begin
              state         <= OUT;
              bus.res_data  <= '0;
              bus.res_ovf   <= 1'b0;
              bus.res_valid <= 1'b1;
            end
          end
        end

        CLEAR: begin
          state    <= ISSUE;
          prev_acc <= '0;
          if (count_nxt != '0) begin
            mac_en <= 1'b1;
            mac_a  <= head_nxt_c[3:0];
            mac_b  <= head_nxt_c[7:4];
          end
        end

        ISSUE: begin
          if (mac_en) remaining <= remaining - LEN_W'(1);
          if (mac_en && (remaining == LEN_W'(1))) begin
            state <= DRAIN;
          end else if (count_nxt != '0) begin
            mac_en <= 1'b1;
            mac_a  <= head_nxt_c[3:0];
            mac_b  <= head_nxt_c[7:4];
          end
        end

        DRAIN: begin
          state         <= OUT;
          bus.res_data  <= acc_in;
          bus.res_valid <= 1'b1;
        end

        OUT: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            bus.res_valid <= 1'b0;
            busy          <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer with a behavioural MAC and an operand scoreboard.
module tb_mac_operand_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LEN_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [3:0]       mac_a;
  logic [3:0]       mac_b;
  logic             mac_en;
  logic             mac_clr;
  logic [7:0]       acc;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;
  int en_total = 0;
  int clr_total = 0;
  logic [7:0] model_q[$];

  mac_operand_sequencer_if bus ();

  mac_operand_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .start   (start),
    .len     (len),
    .mac_a   (mac_a),
    .mac_b   (mac_b),
    .mac_en  (mac_en),
    .mac_clr (mac_clr),
    .acc_in  (acc),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC with a registered accumulator.
  always @(posedge clk or posedge rst) begin
    if (rst)          acc <= 8'd0;
    else if (mac_clr) acc <= 8'd0;
    else if (mac_en)  acc <= acc + 8'(8'(mac_a) * 8'(mac_b));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard sampled mid-cycle: every issued pair must be the oldest accepted pair.
  always @(negedge clk) begin
    if (rst) begin
      model_q.delete();
    end else begin
      if (mac_en) begin
        en_total++;
        if (model_q.size() == 0) begin
          check("mac_en_on_empty", 32'd1, 32'd0);
        end else begin
          check("mac_operands", {24'd0, mac_b, mac_a}, {24'd0, model_q[0]});
          void'(model_q.pop_front());
        end
      end
      if (mac_clr) clr_total++;
      if (bus.in_valid && bus.in_ready) model_q.push_back(bus.in_data);
    end
  end

  task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
    int waits;
    waits = 0;
    while (!bus.in_ready && waits < 100) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!bus.in_ready) check("push_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = {b, a};
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Start a job, wait for the result, check it, optionally hold it, then accept it.
  task automatic do_job(input string tag, input int n, input logic [7:0] exp_data,
                        input logic exp_ovf, input int exp_lat, input int hold, input bit poke);
    int edges;
    int en0;
    int clr0;
    bit seen;
    en0   = en_total;
    clr0  = clr_total;
    edges = 0;
    seen  = 1'b0;
    start = 1'b1;
    len   = LEN_W'(n);
    while (!seen && edges < 300) begin
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      if (poke && edges == 3) begin
        start = 1'b1;
        len   = LEN_W'(1);
      end
      seen = bus.res_valid;
    end
    start = 1'b0;
    if (!seen) begin
      check($sformatf("%s_timeout", tag), 32'd0, 32'd1);
      return;
    end
    if (exp_lat != 0) check($sformatf("%s_latency", tag), 32'(edges), 32'(exp_lat));
    check($sformatf("%s_data", tag), {24'd0, bus.res_data}, {24'd0, exp_data});
    check($sformatf("%s_ovf", tag), {31'd0, bus.res_ovf}, {31'd0, exp_ovf});
    check($sformatf("%s_en_cycles", tag), 32'(en_total - en0), 32'(n));
    check($sformatf("%s_clr_cycles", tag), 32'(clr_total - clr0), (n != 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s_hold_valid", tag), {31'd0, bus.res_valid}, 32'd1);
      check($sformatf("%s_hold_data", tag), {24'd0, bus.res_data}, {24'd0, exp_data});
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check($sformatf("%s_accept_valid", tag), {31'd0, bus.res_valid}, 32'd0);
    check($sformatf("%s_accept_busy", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s_accept_data", tag), {24'd0, bus.res_data}, {24'd0, exp_data});
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_mac_en", tag), {31'd0, mac_en}, 32'd0);
    check($sformatf("%s_mac_clr", tag), {31'd0, mac_clr}, 32'd0);
    check($sformatf("%s_mac_ops", tag), {24'd0, mac_b, mac_a}, 32'd0);
    check($sformatf("%s_busy", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s_res_valid", tag), {31'd0, bus.res_valid}, 32'd0);
    check($sformatf("%s_res_data", tag), {24'd0, bus.res_data}, 32'd0);
    check($sformatf("%s_res_ovf", tag), {31'd0, bus.res_ovf}, 32'd0);
    check($sformatf("%s_in_ready", tag), {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    len           = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Asynchronous reset mid-CLEAR.
    push_pair(4'd2, 4'd2);
    start = 1'b1;
    len   = LEN_W'(1);
    @(posedge clk); #1;
    start = 1'b0;
    check("t1_clr_before_rst", {31'd0, mac_clr}, 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("t1_async");
    @(posedge clk); #3 rst = 1'b0;

    // Basic dot product: 3*4 + 5*6 + 2*7 = 56, result held while res_ready is low.
    push_pair(4'd3, 4'd4);
    push_pair(4'd5, 4'd6);
    push_pair(4'd2, 4'd7);
    do_job("t2", 3, 8'h38, 1'b0, 6, 4, 1'b0);

    // Wrap: 225 + 225 = 450 -> 0xC2 with overflow; next job clears the flag.
    push_pair(4'd15, 4'd15);
    push_pair(4'd15, 4'd15);
    do_job("t3_wrap", 2, 8'hC2, 1'b1, 5, 0, 1'b0);
    push_pair(4'd1, 4'd1);
    do_job("t3_next", 1, 8'h01, 1'b0, 4, 0, 1'b0);

    // Stalls on an empty FIFO: 1*2 + 3*4 + 5*6 + 7*8 = 100; a start during ISSUE is ignored.
    fork
      do_job("t4_stall", 4, 8'd100, 1'b0, 0, 0, 1'b1);
      begin
        repeat (3) @(posedge clk); #1;
        push_pair(4'd1, 4'd2);
        repeat (2) @(posedge clk); #1;
        push_pair(4'd3, 4'd4);
        repeat (2) @(posedge clk); #1;
        push_pair(4'd5, 4'd6);
        repeat (2) @(posedge clk); #1;
        push_pair(4'd7, 4'd8);
      end
    join

    // Full FIFO: eight pairs (i+1)*2 sum to 72; a ninth offer is refused.
    for (int i = 0; i < 8; i++) push_pair(4'(i + 1), 4'd2);
    check("t4_full_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = {4'd15, 4'd15};
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("t4_full_still", {31'd0, bus.in_ready}, 32'd0);
    do_job("t4_full", 8, 8'd72, 1'b0, 11, 0, 1'b0);
    push_pair(4'd1, 4'd1);
    do_job("t4_no_ninth", 1, 8'd1, 1'b0, 4, 0, 1'b0);

    // len=0 answers at once without touching the MAC; the queued pair survives.
    push_pair(4'd2, 4'd3);
    do_job("t5_zero", 0, 8'd0, 1'b0, 1, 0, 1'b0);
    do_job("t5_kept", 1, 8'd6, 1'b0, 4, 0, 1'b0);

    // Reset after two issued pairs, then a fresh job: 4*5 + 6*7 = 62.
    push_pair(4'd1, 4'd1);
    push_pair(4'd2, 4'd2);
    push_pair(4'd3, 4'd3);
    push_pair(4'd4, 4'd4);
    push_pair(4'd5, 4'd5);
    begin
      int en0;
      int guard;
      en0   = en_total;
      guard = 0;
      start = 1'b1;
      len   = LEN_W'(5);
      @(posedge clk); #1;
      start = 1'b0;
      while ((en_total - en0) < 2 && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      check("t6_en_before_rst", {31'd0, mac_en}, 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    @(posedge clk); #3 rst = 1'b0;
    push_pair(4'd4, 4'd5);
    push_pair(4'd6, 4'd7);
    do_job("t6_fresh", 2, 8'd62, 1'b0, 5, 0, 1'b0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
- Front-end controller for the 4x4 vedic MAC datapath.
- Buffers {b,a} operand pairs arriving on a valid/ready stream, then on a start command clears the MAC and issues a programmed number of pairs to it.
- Waits for the MAC's registered accumulator, tracks 8-bit wrap-around, and presents the dot-product result on a valid/ready result port.
- Sits between the host pin interface and the MAC: it writes operands to the MAC and reads its result back.

Parameters:
DEPTH, 8, operand FIFO depth in pairs; power of two, >= 2.
LEN_W, 8, width of the len command field.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  operand pair offered.
in_ready  out  1  FIFO not full.
in_data  in  8  operand pair; [3:0]=a, [7:4]=b.
start  in  1  begin a dot product; sampled only in IDLE.
len  in  LEN_W  number of pairs to issue; sampled with start.
mac_a  out  4  operand a to MAC.
mac_b  out  4  operand b to MAC.
mac_en  out  1  MAC accumulates mac_a*mac_b at the next edge.
mac_clr  out  1  MAC clears its accumulator at the next edge.
acc_in  in  8  MAC registered accumulator.
res_valid  out  1  result available.
res_ready  in  1  result consumer accepts.
res_data  out  8  captured accumulator, mod 256.
res_ovf  out  1  sticky: the accumulator wrapped at least once during this job.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous): FIFO emptied and state=IDLE. All outputs 0 except in_ready=1; this includes mac_en, mac_clr, res_valid, res_data, res_ovf and busy. prev_acc and remaining count are 0.
- FIFO: push when in_valid && in_ready, in any state. in_ready = (count != DEPTH).
  - A push and a pop in the same cycle leave count unchanged.
  - The head is popped only in ISSUE.
  - mac_a/mac_b = FIFO head while mac_en=1, else 0.
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, OUT.
- IDLE:
  - start && len!=0 -> CLEAR; latch remaining=len, res_ovf<=0.
  - start && len==0 -> OUT with res_data=0, res_ovf=0. The MAC is not touched.
- CLEAR: one cycle, mac_clr=1, mac_en=0, prev_acc<=0. Then -> ISSUE.
- ISSUE:
  - If count!=0: mac_en=1, pop the head, remaining-=1.
  - If count==0: mac_en=0 (stall), no decrement. Stalls are unbounded.
  - The pop that makes remaining reach 0 -> DRAIN.
- DRAIN: one cycle, mac_en=0. At its closing edge res_data<=acc_in, final overflow check applied, -> OUT.
- OUT:
  - res_valid=1; res_data and res_ovf stay stable until res_ready.
  - res_valid && res_ready -> IDLE, res_valid<=0. res_data and res_ovf hold their last values.
- Overflow tracking:
  - On every edge following a cycle with mac_en=1: if acc_in < prev_acc then res_ovf<=1; prev_acc<=acc_in.
  - The comparison is valid because every product is <= 225 < 256, so a wrap always yields a smaller value.
  - A zero product gives equal values and is not a wrap.
- Latency with the FIFO holding >= len pairs: start sampled at edge E0, mac_clr high in cycle 1, mac_en high in cycles 2..N+1, DRAIN in cycle N+2, res_valid high from cycle N+3. That is res_valid rises N+3 edges after the start edge.
- start while busy is ignored and len is not re-sampled. Extra FIFO pairs beyond len remain queued for the next job.
- Reset mid-job (any state): returns to IDLE immediately, FIFO flushed, mac_en/mac_clr drop asynchronously, pending result discarded.
- The MAC model assumed by the bench:
  - acc <= 0 on mac_clr.
  - acc <= acc + a*b (mod 256) on mac_en.
  - acc_in is registered, visible the cycle after the edge.

Test Plan:
1. Assert rst mid-cycle -> all outputs 0, in_ready=1, busy=0 without waiting for a clock edge.
2. Push (a,b)=(3,4),(5,6),(2,7); start len=3 -> mac_clr 1 cycle, mac_en 3 consecutive cycles, res_valid 6 edges after start, res_data=56 (0x38), res_ovf=0; hold res_ready=0 for 4 cycles -> data stable.
3. Push (15,15) twice; start len=2 -> res_data=0xC2 (450 mod 256), res_ovf=1; next job (1,1) len=1 -> res_data=1, res_ovf=0.
4. Start len=4 with FIFO empty, then push one pair every 3 cycles -> mac_en only on cycles where count!=0, result matches reference sum; fill 8 pairs in IDLE -> in_ready=0 and a 9th push is not stored; start asserted during ISSUE is ignored.
5. start len=0 -> res_valid next cycle, res_data=0, res_ovf=0, mac_clr and mac_en never asserted; queued FIFO pairs are left intact.
6. Queue 5 pairs, start len=5, assert rst after 2 mac_en cycles -> mac_en=0 at once, state IDLE, count=0; a fresh job after release computes correctly.
